// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: icache, dcache and RAM signals of the memory arbiter.
// slave is the arbiter side, master the caches/RAM side.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;

  modport slave (
    input  iREN,
    input  iaddr,
    input  dREN,
    input  dWEN,
    input  daddr,
    input  dstore,
    input  ramload,
    output iwait,
    output iload,
    output dwait,
    output dload,
    output ramREN,
    output ramWEN,
    output ramaddr,
    output ramstore
  );

  modport master (
    output iREN,
    output iaddr,
    output dREN,
    output dWEN,
    output daddr,
    output dstore,
    output ramload,
    input  iwait,
    input  iload,
    input  dwait,
    input  dload,
    input  ramREN,
    input  ramWEN,
    input  ramaddr,
    input  ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants icache/dcache one at a time to a single-cycle RAM.
// Define MEM_ARB_RR_EN for round-robin; default is fixed dcache priority.
module mem_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACCESS
  } state_e;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  gnt_e       gnt_q, gnt_d;
  gnt_e       pick;
  logic       i_req;
  logic       d_req;
  logic       gnt_req;
  logic       unused_addr_bits;

`ifdef MEM_ARB_RR_EN
  gnt_e       last_q, last_d;
`endif

  assign i_req   = bus.iREN;
  assign d_req   = bus.dREN | bus.dWEN;
  assign gnt_req = (gnt_q == GNT_D) ? d_req : i_req;

  assign unused_addr_bits = ^{bus.iaddr[1:0], bus.daddr[1:0]};

`ifdef MEM_ARB_RR_EN
  // on a tie, the requester that did not complete last goes next
  always_comb begin
    pick = GNT_I;
    if (i_req && d_req)
      pick = (last_q == GNT_D) ? GNT_I : GNT_D;
    else if (d_req)
      pick = GNT_D;
  end
`else
  always_comb begin
    pick = GNT_I;
    if (d_req)
      pick = GNT_D;
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= GNT_I;
`ifdef MEM_ARB_RR_EN
      last_q  <= GNT_D;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = pick;
          cnt_d   = 4'(LAT);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!gnt_req)
          state_d = IDLE;
        else if (cnt_q == 4'd1)
          state_d = ACCESS;
        else
          cnt_d = cnt_q - 4'd1;
      end
      ACCESS: begin
        state_d = IDLE;
`ifdef MEM_ARB_RR_EN
        last_d  = gnt_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // dcache read/write is taken from the live strobes in the access cycle
  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    unique case (1'b1)
      (state_q == ACCESS) && (gnt_q == GNT_I): begin
        bus.ramaddr = {bus.iaddr[31:2], 2'b00};
        bus.ramREN  = 1'b1;
        bus.iload   = bus.ramload;
        bus.iwait   = 1'b0;
      end
      (state_q == ACCESS) && (gnt_q == GNT_D) && bus.dWEN: begin
        bus.ramaddr  = {bus.daddr[31:2], 2'b00};
        bus.ramWEN   = 1'b1;
        bus.ramstore = bus.dstore;
        bus.dwait    = 1'b0;
      end
      (state_q == ACCESS) && (gnt_q == GNT_D) && !bus.dWEN: begin
        bus.ramaddr = {bus.daddr[31:2], 2'b00};
        bus.ramREN  = 1'b1;
        bus.dload   = bus.ramload;
        bus.dwait   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, random transactions against a reference
// model, and hand sequences for abort, reset-in-access and held requests.
module tb_mem_arbiter;
  localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus();

  mem_arbiter #(.LAT(LAT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 32'h41) return 32'hDEADBEEF;
    return {16'hC0DE, idx[15:0]};
  endfunction

  logic [31:0] ram    [0:1023];
  bit          ram_wr [0:1023];

  assign bus.ramload = !bus.ramREN ? 32'h0 :
    ram_wr[bus.ramaddr[11:2]] ? ram[bus.ramaddr[11:2]] :
    init_word(int'(bus.ramaddr[11:2]));

  always @(posedge CLK) begin
    if (bus.ramWEN) begin
      ram[bus.ramaddr[11:2]]    <= bus.ramstore;
      ram_wr[bus.ramaddr[11:2]] <= 1'b1;
    end
  end

  logic [31:0] mdl [int];
  bit          mdl_last_d = 1'b1;

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    int i;
    i = int'(a[11:2]);
    return mdl.exists(i) ? mdl[i] : init_word(i);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  typedef struct {
    bit          ir;
    bit          dr;
    bit          dw;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] ds;
    int          iexp;
    int          dexp;
    logic [31:0] il;
    logic [31:0] dl;
  } vec_t;

  task automatic clr_inputs();
    bus.iREN   = 1'b0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dstore = '0;
  endtask

  // entered at posedge+1 with the DUT idle; that cycle is cycle 0
  task automatic run_txn(input vec_t v);
    int last_k;
    bit ai;
    bit ad;
    logic [31:0] ea;
    last_k = (v.iexp > v.dexp) ? v.iexp : v.dexp;
    bus.iREN   = v.ir;
    bus.iaddr  = v.ia;
    bus.dREN   = v.dr;
    bus.dWEN   = v.dw;
    bus.daddr  = v.da;
    bus.dstore = v.ds;
    for (int k = 0; k <= last_k + 1; k++) begin
      @(negedge CLK);
      ai = (k == v.iexp);
      ad = (k == v.dexp);
      ea = ai ? {v.ia[31:2], 2'b00} :
           ad ? {v.da[31:2], 2'b00} : 32'h0;
      chk("iwait", k, bus.iwait, !ai);
      chk("dwait", k, bus.dwait, !ad);
      chk("iload", k, bus.iload, ai ? v.il : 32'h0);
      chk("dload", k, bus.dload, (ad && !v.dw) ? v.dl : 32'h0);
      chk("ramREN", k, bus.ramREN, ai || (ad && !v.dw));
      chk("ramWEN", k, bus.ramWEN, ad && v.dw);
      chk("ramaddr", k, bus.ramaddr, ea);
      chk("ramstore", k, bus.ramstore, (ad && v.dw) ? v.ds : 32'h0);
      @(posedge CLK);
      #1;
      if (ai) bus.iREN = 1'b0;
      if (ad) begin
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
      end
    end
    if (v.dw) mdl[int'(v.da[11:2])] = v.ds;
    if (v.ir && (v.dr || v.dw)) mdl_last_d = (v.dexp > v.iexp);
    else mdl_last_d = !v.ir;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_iwait"}, 0, bus.iwait, 32'h1);
    chk({nm, "_dwait"}, 0, bus.dwait, 32'h1);
    chk({nm, "_iload"}, 0, bus.iload, 32'h0);
    chk({nm, "_dload"}, 0, bus.dload, 32'h0);
    chk({nm, "_ramREN"}, 0, bus.ramREN, 32'h0);
    chk({nm, "_ramWEN"}, 0, bus.ramWEN, 32'h0);
    chk({nm, "_ramaddr"}, 0, bus.ramaddr, 32'h0);
    chk({nm, "_ramstore"}, 0, bus.ramstore, 32'h0);
  endtask

  vec_t tbl [7];

  initial begin
    vec_t v;
    int kind;
    bit i_first;
    logic [31:0] dlx;

    tbl[0] = '{1, 1, 0, 32'h104, 32'h20, 32'h0,
               RR ? 3 : 7, RR ? 7 : 3, 32'hDEADBEEF, 32'hC0DE0008};
    tbl[1] = '{1, 0, 0, 32'h104, 32'h0, 32'h0,
               3, -1, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{0, 0, 1, 32'h0, 32'h203, 32'h12345678,
               -1, 3, 32'h0, 32'h0};
    tbl[3] = '{0, 1, 0, 32'h0, 32'h200, 32'h0,
               -1, 3, 32'h0, 32'h12345678};
    tbl[4] = '{0, 1, 1, 32'h0, 32'h30, 32'hCAFEF00D,
               -1, 3, 32'h0, 32'h0};
    tbl[5] = '{0, 1, 0, 32'h0, 32'h32, 32'h0,
               -1, 3, 32'h0, 32'hCAFEF00D};
    tbl[6] = '{1, 0, 0, 32'h3, 32'h0, 32'h0,
               3, -1, 32'hC0DE0000, 32'h0};

    nRST = 1'b0;
    clr_inputs();
    #1;
    chk_reset_outs("reset");
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    for (int t = 0; t < 7; t++) run_txn(tbl[t]);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      v.ir = (kind == 0) || (kind >= 3);
      v.dr = (kind == 1) || (kind == 3);
      v.dw = (kind == 2) || (kind == 4);
      if (v.dw) v.dr = 1'($urandom_range(0, 1));
      v.ia = $urandom;
      v.da = $urandom;
      v.ds = $urandom;
      v.iexp = -1;
      v.dexp = -1;
      i_first = RR ? mdl_last_d : 1'b0;
      if (v.ir && (v.dr || v.dw)) begin
        v.iexp = i_first ? LAT + 1 : 2 * LAT + 3;
        v.dexp = i_first ? 2 * LAT + 3 : LAT + 1;
      end else if (v.ir) begin
        v.iexp = LAT + 1;
      end else begin
        v.dexp = LAT + 1;
      end
      v.dl = mdl_rd(v.da);
      v.il = (v.ir && v.dw && !i_first && (v.ia[11:2] == v.da[11:2]))
             ? v.ds : mdl_rd(v.ia);
      run_txn(v);
    end

    // abort: fetch dropped mid-wait, then a dcache read proves IDLE
    dlx = mdl_rd(32'h200);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h104;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("abort_iwait", k, bus.iwait, 32'h1);
      chk("abort_iload", k, bus.iload, 32'h0);
      chk("abort_ramREN", k, bus.ramREN, k == 6);
      chk("abort_dwait", k, bus.dwait, k != 6);
      chk("abort_dload", k, bus.dload, (k == 6) ? dlx : 32'h0);
      @(posedge CLK);
      #1;
      if (k == 1) bus.iREN = 1'b0;
      if (k == 2) begin
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
      end
      if (k == 6) bus.dREN = 1'b0;
    end
    mdl_last_d = 1'b1;

    // reset asserted during the access cycle
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h104;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rstacc_iwait", k, bus.iwait, 32'h1);
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    chk("rstacc_iwait", 3, bus.iwait, 32'h0);
    chk("rstacc_ramREN", 3, bus.ramREN, 32'h1);
    #2;
    nRST = 1'b0;
    clr_inputs();
    #1;
    chk_reset_outs("rstacc");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("post_rst_ramREN", k, bus.ramREN, 32'h0);
      chk("post_rst_ramWEN", k, bus.ramWEN, 32'h0);
      chk("post_rst_iwait", k, bus.iwait, 32'h1);
      chk("post_rst_dwait", k, bus.dwait, 32'h1);
      @(posedge CLK);
      #1;
    end

    // both requests held high continuously
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h104;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h20;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk("hold_iwait", k, bus.iwait,
          !(RR && ((k == 3) || (k == 11))));
      chk("hold_dwait", k, bus.dwait,
          !(RR ? (k == 7) : ((k == 3) || (k == 7) || (k == 11))));
      @(posedge CLK);
      #1;
    end
    clr_inputs();
    repeat (3) @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the instruction- and data-cache request interfaces. It accepts icache fetches (iREN/iaddr) and dcache reads and writes (dREN/dWEN/daddr/dstore), and grants one requester at a time. Each granted request waits a fixed number of wait states, then performs a single-cycle RAM access. Completion is signalled by dropping the matching `iwait`/`dwait` for exactly one cycle, which is the cycle in which requesting caches fill.

## Interface
- LAT, 2, wait-state cycles before the access cycle; legal range 1..15.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request; held until iwait low.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the icache completion cycle, high otherwise.
- iload  out  32  fetched instruction; valid only while iwait low.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; wins over dREN if both are high.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the dcache completion cycle, high otherwise.
- dload  out  32  read data; valid only while dwait low.
- ramREN  out  1  RAM read strobe, access cycle only.
- ramWEN  out  1  RAM write strobe, access cycle only.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, combinational from ramaddr/ramREN.

## Operation
- States: IDLE, BUSY, ACCESS. Grant register `gnt` ∈ {I, D}. Wait counter `cnt` is 4 bits.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise, latch `gnt` (arbitration below), set cnt=LAT, and go to BUSY.
- BUSY:
  - If the granted request drops, go to IDLE with no RAM access.
  - Else if cnt==1, go to ACCESS.
  - Else decrement cnt.
- ACCESS (one cycle):
  - Drive ramaddr={addr[31:2],2'b00} from the granted requester.
  - D write: ramWEN=1 and ramstore=dstore.
  - Otherwise: ramREN=1, and ramload is routed to iload or dload.
  - The granted wait signal goes low; go to IDLE unconditionally.
- The request type for D (read or write) is re-evaluated in ACCESS from the live dWEN/dREN.
- iwait/dwait are high in every cycle except the matching ACCESS cycle, including when no request is pending. The icache relies on this: it fills whenever iwait is low.
- iload/dload are 0 outside their completion cycle. ramaddr/ramstore are 0 outside ACCESS.
- The non-granted requester is simply held off; its wait stays high.

## Timing
- Reset (nRST low, asynchronous): state=IDLE, cnt=0, gnt=I, iwait=dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Reset mid-operation aborts the transfer immediately; no RAM strobe is issued.
- Latency: a request first seen high in IDLE cycle 0 gets BUSY in cycles 1..LAT, ACCESS (wait low) in cycle LAT+1, and IDLE in cycle LAT+2.
- Back-to-back: at least one IDLE cycle separates consecutive accesses. Throughput is one access per LAT+2 cycles.
- Simultaneous I and D requests in IDLE are resolved by the arbitration policy (Configuration).
- A request arriving during BUSY/ACCESS is first seen in the next IDLE cycle.
- cnt never wraps: it is loaded with LAT ≥ 1 and only decremented while >1.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A `last` flag records the most recent completed grant. On a simultaneous request, grant the requester not in `last`. Reset value of `last` is D, so the first tie goes to I.
- MEM_ARB_RR_EN undefined: fixed priority, D always wins over I.
- In both modes a lone requester is granted immediately.

## Test plan
- Single fetch, LAT=2: iREN=1, iaddr=0x104, RAM[0x104]=0xDEADBEEF.
  - iwait low only in cycle 3 with iload=0xDEADBEEF; ramREN=1 only in cycle 3.
- Simultaneous iREN and dREN, fixed priority:
  - dwait low in cycle 3, then iwait low in cycle 7.
  - With MEM_ARB_RR_EN and iREN/dREN held high continuously: grants alternate I, D, I, with completions at cycles 3, 7, 11.
- dWEN=1, daddr=0x203 (unaligned), dstore=0x12345678:
  - ramWEN=1 and ramaddr=0x200 in cycle 3.
  - dwait low in the same cycle; dload=0.
- Abort: iREN dropped in cycle 2 of BUSY.
  - Returns to IDLE in cycle 3 with no ramREN pulse and iwait never low.
- Reset asserted in ACCESS cycle:
  - All outputs take reset values asynchronously; no RAM strobe in any subsequent cycle until a new request.
